mem_drain_streamer: RTL and testbench
=====================================

// Module: mem_drain_streamer
// PURPOSE
// - Downstream consumer of the APB-loaded buffer RAM. When the APB wrapper raises its
//   "last word written" interrupt, this block reads the whole RAM through the RAM's
//   read port and emits it as a valid/ready stream to the datapath.
// - Runs on the APB clock domain (PCLK). RAM read latency: 1 cycle.
// - Signals completion with a one-cycle done interrupt.
// PARAMETERS
// - DATA_WIDTH  8  RAM word and stream data width.
// - ADDR_WIDTH  6  RAM word-address width. Drain length = 2**ADDR_WIDTH words.
// PORTS
// - PCLK         in   1           Clock.
// - PRESETN      in   1           Reset. Asynchronous, active-low.
// - start_i      in   1           Level from the wrapper INT_OUT. Rising edge requests a drain.
// - ram_rd_en    out  1           RAM read strobe.
// - ram_raddr    out  ADDR_WIDTH  RAM read word address.
// - ram_rdata    in   DATA_WIDTH  RAM read data. Valid the cycle after ram_rd_en.
// - m_valid      out  1           Stream beat valid.
// - m_data       out  DATA_WIDTH  Stream beat data.
// - m_last       out  1           Marks the final beat (address 2**ADDR_WIDTH-1).
// - m_ready      in   1           Stream sink ready.
// - busy         out  1           High from drain start until the done pulse.
// - done_irq     out  1           One-cycle pulse when the drain completes.
// - overrun_err  out  1           One-cycle pulse when a start edge arrives while busy.
// - checksum     out  DATA_WIDTH  Sum of the drained words (see CONFIGURATION).
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, address counter 0, FIFO empty,
//   start_q 0, in-flight read discarded.
// - Reset is asynchronous and may hit mid-drain. The block returns to IDLE
//   immediately and does not resume.
// - Start edge: start_i & ~start_q, where start_q is a registered copy of start_i.
//   - Held-high start_i triggers exactly one drain.
//   - start_i already high at reset release triggers one drain.
// - FSM states: IDLE, RUN, FLUSH.
//   - IDLE -> RUN: on a start edge. Clear the address counter and checksum.
//   - RUN: issue reads at addresses 0..2**ADDR_WIDTH-1 in order.
//     After the read of the last address issues, go to FLUSH.
//   - FLUSH: wait until the in-flight read has landed, the FIFO is empty and the
//     last beat has handshaken. Then pulse done_irq for 1 cycle and go to IDLE.
//   - busy = (state != IDLE).
// - RAM interface:
//   - ram_rd_en and ram_raddr are combinational from the state and address register.
//   - Read data is pushed into a 2-entry output FIFO in the cycle ram_rdata is valid.
//   - Each pushed word carries a last tag (address == all ones).
// - Read credit rule:
//   - Issue a read only if (fifo_count + inflight - pop_this_cycle) < 2.
//   - The FIFO never overflows, and reads sustain 1 beat/cycle while m_ready is held high.
// - Stream rules:
//   - m_valid = FIFO non-empty. m_data and m_last come from the FIFO head.
//   - Handshake: m_valid & m_ready.
//   - m_data and m_last must stay stable while m_valid & ~m_ready.
//   - No beat is dropped or duplicated.
// - Latency: start edge sampled in cycle 0 -> ram_rd_en in cycle 1 -> first m_valid in cycle 3.
// - Done timing: done_irq is asserted in the cycle after the m_last handshake.
// - Simultaneous events:
//   - FIFO push and pop in the same cycle leave the count unchanged.
//   - A start edge in the done_irq cycle is an overrun (still busy).
//   - A start edge in the cycle after done_irq starts a new drain.
// - Overrun: a start edge while busy pulses overrun_err for 1 cycle.
//   The active drain is unaffected.
// - Address counter is exactly ADDR_WIDTH bits. Its wrap to 0 is never used as an
//   issued address within one drain.
// CONFIGURATION
// - DRAIN_CHECKSUM_EN defined:
//   - checksum = mod-2**DATA_WIDTH sum of every handshaken beat.
//   - Cleared on a drain start.
//   - Holds its value from done_irq until the next start.
// - DRAIN_CHECKSUM_EN undefined: checksum tied to 0. No adder is built.
// TESTING
// - RAM[i]=i, m_ready=1, start pulse -> 64 consecutive beats 0x00..0x3F.
//   First m_valid 3 cycles after the edge. m_last only on 0x3F.
//   done_irq 1 cycle after the last handshake. busy low afterwards.
// - Same data, m_ready low for 10 cycles at beat 20 and then toggling every cycle ->
//   exact sequence 0x00..0x3F, data stable while stalled, FIFO count never > 2.
// - Second start edge at beat 30 -> overrun_err single pulse.
//   The stream is still exactly 64 beats with one done_irq.
// - PRESETN low at beat 20 -> all outputs 0 immediately.
//   Next start -> stream restarts at 0x00 with 64 beats.
// - start_i held high across 3 full drain durations -> exactly one drain, one done_irq.
// - DRAIN_CHECKSUM_EN, RAM[i]=i -> checksum = 0xE0 at done_irq.
//   Without the macro, checksum stays 0.

Source files
------------

// File: rtl/mem_drain_streamer.sv
// mem_drain_streamer
// Drains the APB-loaded buffer RAM as a valid/ready stream once the wrapper
// raises its "last word written" level. The RAM has one cycle of read latency.
// Read data lands in a 2-entry output FIFO, and a credit rule keeps that FIFO
// from overflowing.
// Optional feature macro: DRAIN_CHECKSUM_EN. When it is defined, a running
// mod-2**DATA_WIDTH sum of the handshaken beats is kept. When it is not
// defined, checksum is tied to zero.
module mem_drain_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  start_i,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done_irq,
    output logic                  overrun_err,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  start_q;
    logic                  start_edge;
    logic                  addr_is_last;
    logic                  last_hs;

    // read issued in the previous cycle; its data is on ram_rdata now
    logic                  rd_vld_p1;
    logic                  rd_last_p1;

    logic [1:0]            fifo_count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic                  fifo_last [2];

    logic                  push;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  credit_ok;
    logic                  issue;
    logic                  drain_done;

    // Edge detect, read credit, stream head and completion decode
    always_comb begin
        start_edge   = start_i & ~start_q;
        addr_is_last = (addr == {ADDR_WIDTH{1'b1}});

        m_valid      = (fifo_count != 2'd0);
        pop          = m_valid & m_ready;
        push         = rd_vld_p1;

        // words already held plus the word about to land, minus the one leaving now
        occupancy    = {1'b0, fifo_count} + {2'b00, rd_vld_p1} - {2'b00, pop};
        credit_ok    = (occupancy < 3'd2);
        issue        = (state == ST_RUN) && credit_ok;

        ram_rd_en    = issue;
        ram_raddr    = addr;

        // gate the head so an empty FIFO always presents zero data
        m_data       = m_valid ? fifo_data[rd_ptr] : '0;
        m_last       = m_valid & fifo_last[rd_ptr];

        drain_done   = (state == ST_FLUSH) && !rd_vld_p1 &&
                       (fifo_count == 2'd0) && last_hs;
        done_irq     = drain_done;
        busy         = (state != ST_IDLE);
    end

    // Drain FSM: address sequencing and last-handshake tracking
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state   <= ST_IDLE;
            addr    <= '0;
            last_hs <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state   <= ST_RUN;
                        addr    <= '0;
                        last_hs <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        addr <= addr + ADDR_WIDTH'(1);
                        if (addr_is_last) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (drain_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (pop && m_last) begin
                last_hs <= 1'b1;
            end
        end
    end

    // Start level history and the overrun pulse
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            start_q     <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            start_q     <= start_i;
            overrun_err <= start_edge & busy;
        end
    end

    // ---- stage p0 -> p1: RAM read issued, tag travels with it ----
    // In-flight read tracking; reset discards any outstanding read
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rd_vld_p1  <= 1'b0;
            rd_last_p1 <= 1'b0;
        end else begin
            rd_vld_p1  <= issue;
            rd_last_p1 <= issue & addr_is_last;
        end
    end

    // ---- stage p1 -> FIFO: landed read data is captured ----
    // FIFO pointers and occupancy
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are qualified by the pointers so no reset is needed
    always_ff @(posedge PCLK) begin
        if (push) begin
            fifo_data[wr_ptr] <= ram_rdata;
            fifo_last[wr_ptr] <= rd_last_p1;
        end
    end

`ifdef DRAIN_CHECKSUM_EN
    // Running sum of handshaken beats, restarted on each drain start
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            checksum <= '0;
        end else if ((state == ST_IDLE) && start_edge) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + m_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_mem_drain_streamer.sv
// Bench for mem_drain_streamer: RAM model, randomized sink, stream reference model.
module tb_mem_drain_streamer;

    localparam int DW    = 8;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          PCLK      = 1'b0;
    logic          PRESETN   = 1'b0;
    logic          start_i   = 1'b0;
    logic          m_ready   = 1'b1;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_rd_en;
    logic [AW-1:0] ram_raddr;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done_irq;
    logic          overrun_err;
    logic [DW-1:0] checksum;

    int checks = 0;
    int errors = 0;

    mem_drain_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .start_i(start_i),
        .ram_rd_en(ram_rd_en), .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done_irq(done_irq), .overrun_err(overrun_err), .checksum(checksum)
    );

    always #5 PCLK = ~PCLK;

    // RAM with one cycle of read latency
    logic [DW-1:0] ram [DEPTH];
    always @(posedge PCLK) if (ram_rd_en) ram_rdata <= ram[ram_raddr];

    int cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_cksum();
        int s = 0;
`ifdef DRAIN_CHECKSUM_EN
        for (int i = 0; i < DEPTH; i++) s += int'(ram[i]);
`endif
        return DW'(s % (1 << DW));
    endfunction

    // monitor / reference-model state
    bit            mon_en = 0;
    int            rmode = 0;
    int            beat_idx, done_cnt, ovr_cnt, first_vld, hs_cyc, stall_n, max_fill;
    logic          stall_prev, stall_last;
    logic [DW-1:0] stall_data;

    task automatic clear_mon();
        beat_idx = 0; done_cnt = 0; ovr_cnt = 0; first_vld = -1; hs_cyc = 0;
        stall_n = 0; max_fill = 0; stall_prev = 0; stall_last = 0; stall_data = '0;
    endtask

    // Sink: always ready, the scripted stall, or random back-pressure
    always @(posedge PCLK) begin
        #1;
        case (rmode)
            0: m_ready = 1'b1;
            1: begin
                if (beat_idx >= 20 && stall_n < 10) begin
                    m_ready = 1'b0;
                    stall_n++;
                end else if (stall_n >= 10) m_ready = ~m_ready;
                else m_ready = 1'b1;
            end
            default: m_ready = ($urandom_range(0, 9) < 7);
        endcase
    end

    // Stream monitor: every beat must be RAM[k] in order, last only on k = DEPTH-1
    always @(negedge PCLK) begin
        if (mon_en) begin
            if (int'(dut.fifo_count) > max_fill) max_fill = int'(dut.fifo_count);
            if (stall_prev) begin
                check("stall_valid", m_valid, 1);
                check("stall_data", m_data, stall_data);
                check("stall_last", m_last, stall_last);
            end
            if (m_valid && first_vld < 0) first_vld = cyc;
            if (m_valid && m_ready) begin
                check("beat_data", m_data, ram[beat_idx % DEPTH]);
                check("beat_last", m_last, (beat_idx % DEPTH) == DEPTH - 1);
                if (m_last) hs_cyc = cyc;
                beat_idx++;
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
            stall_last = m_last;
            if (done_irq) begin
                done_cnt++;
                check("done_latency", cyc - hs_cyc, 1);
                check("done_busy", busy, 1);
                check("done_beats", beat_idx, DEPTH);
                check("done_cksum", checksum, exp_cksum());
            end
            if (overrun_err) ovr_cnt++;
        end
    end

    task automatic pulse_start(output int t0);
        @(posedge PCLK); #1 start_i = 1'b1; t0 = cyc;
        @(posedge PCLK); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done_irq && n < budget) begin @(negedge PCLK); n++; end
        if (!done_irq) check("done_timeout", 0, 1);
    endtask

    task automatic wait_beats(input int k);
        int n = 0;
        while (beat_idx < k && n < 1000) begin @(negedge PCLK); n++; end
        if (beat_idx < k) check("beat_timeout", beat_idx, k);
    endtask

    task automatic end_checks(input int exp_ovr);
        check("beats", beat_idx, DEPTH);
        check("dones", done_cnt, 1);
        check("overruns", ovr_cnt, exp_ovr);
        check("busy_after", busy, 0);
        check("cksum_hold", checksum, exp_cksum());
        check("fifo_max_le2", max_fill <= 2, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, ram_rd_en, 0);
        check({tag, "_raddr"}, ram_raddr, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done_irq, 0);
        check({tag, "_ovr"}, overrun_err, 0);
        check({tag, "_cksum"}, checksum, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
        clear_mon();
        repeat (3) @(posedge PCLK);
        #1 check_all_zero("reset");
        PRESETN = 1'b1;

        // ramp data, sink always ready: latency and full stream
        @(posedge PCLK); #1 clear_mon(); mon_en = 1;
        pulse_start(t0);
        wait_done(400);
        check("first_valid_latency", first_vld - t0, 3);
        repeat (3) @(posedge PCLK); #1 end_checks(0);

        // scripted stall at beat 20, then toggling ready
        clear_mon(); rmode = 1;
        pulse_start(t0);
        wait_done(600);
        repeat (3) @(posedge PCLK); #1 end_checks(0);
        rmode = 0;

        // second start edge mid-drain
        clear_mon();
        pulse_start(t0);
        wait_beats(30);
        @(posedge PCLK); #1 start_i = 1'b1;
        @(posedge PCLK); #1 start_i = 1'b0;
        check("overrun_pulse", overrun_err, 1);
        @(posedge PCLK); #1 check("overrun_single", overrun_err, 0);
        wait_done(400);
        repeat (3) @(posedge PCLK); #1 end_checks(1);

        // asynchronous reset mid-drain, then a clean restart
        clear_mon();
        pulse_start(t0);
        wait_beats(20);
        #2 mon_en = 0; PRESETN = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(posedge PCLK);
        #1 PRESETN = 1'b1;
        clear_mon(); mon_en = 1;
        pulse_start(t0);
        wait_done(400);
        check("restart_latency", first_vld - t0, 3);
        repeat (3) @(posedge PCLK); #1 end_checks(0);

        // random RAM contents under random back-pressure
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
            clear_mon(); rmode = 2;
            pulse_start(t0);
            wait_done(2000);
            repeat (3) @(posedge PCLK); #1 end_checks(0);
        end
        rmode = 0;

        // start held high through reset release and three drain lengths
        mon_en = 0; PRESETN = 1'b0; start_i = 1'b1;
        repeat (2) @(posedge PCLK);
        #1 clear_mon(); mon_en = 1; PRESETN = 1'b1;
        repeat (3 * (DEPTH + 10)) @(posedge PCLK);
        #1 end_checks(0);
        start_i = 1'b0;
        repeat (2) @(posedge PCLK);

        // start edge in the done cycle is an overrun and starts nothing
        #1 clear_mon();
        pulse_start(t0);
        wait_done(400);
        start_i = 1'b1;
        @(posedge PCLK); #1 start_i = 1'b0;
        check("done_cycle_overrun", overrun_err, 1);
        check("done_cycle_idle", busy, 0);
        repeat (3) @(posedge PCLK); #1 end_checks(1);

        // start edge in the cycle after done begins a new drain
        clear_mon();
        pulse_start(t0);
        wait_done(400);
        @(posedge PCLK); #1 start_i = 1'b1;
        @(posedge PCLK); #1 start_i = 1'b0;
        check("after_done_busy", busy, 1);
        check("after_done_no_overrun", overrun_err, 0);
        clear_mon();
        wait_done(400);
        repeat (3) @(posedge PCLK); #1 end_checks(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
